// File: rtl/port_ingress_writer.sv
// Ingress writer for one switch input port: frames header+payload packets and
// pushes only whole packets into the port's input FIFO; dest-0 packets are dropped.
module port_ingress_writer #(
   parameter int FIFO_DEPTH = 256,
   parameter int AW         = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [7:0]    fifo_data,
   output logic          wrreq,
   input  logic          fifo_full,
   input  logic [AW-1:0] fifo_usedw,
   output logic [15:0]   pkt_cnt,
   output logic [15:0]   drop_cnt
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_FWD   = 2'd2,
      S_DROP  = 2'd3
   } state_e;

   localparam logic [AW:0] DEPTH_W = (AW+1)'(FIFO_DEPTH);

   state_e      state_q, state_d;
   logic [7:0]  hdr_q, hdr_d;
   logic [3:0]  rem_q, rem_d;
   logic [15:0] pkt_cnt_q, drop_cnt_q;
   logic        pkt_inc_s, drop_inc_s;
   logic [AW:0] room_s, need_s;
   logic        has_room_s;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Free space vs. whole-packet size, evaluated at AW+1 bits so a full FIFO cannot wrap
   always_comb begin
      room_s     = DEPTH_W - {1'b0, fifo_usedw};
      need_s     = (AW+1)'(hdr_q[7:4]) + (AW+1)'(1);
      has_room_s = (room_s >= need_s);
   end

   // Next-state, handshake and FIFO write decode
   always_comb begin
      state_d    = state_q;
      hdr_d      = hdr_q;
      rem_d      = rem_q;
      in_ready   = 1'b0;
      wrreq      = 1'b0;
      fifo_data  = 8'h00;
      pkt_inc_s  = 1'b0;
      drop_inc_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               hdr_d   = in_data;
               rem_d   = in_data[7:4];
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            fifo_data = hdr_q;
            if (hdr_q[1:0] == 2'b00) begin
               if (rem_q != 4'd0) begin
                  state_d = S_DROP;
               end else begin
                  drop_inc_s = 1'b1;
                  state_d    = S_IDLE;
               end
            end else if (has_room_s && !fifo_full) begin
               wrreq = 1'b1;
               if (rem_q == 4'd0) begin
                  pkt_inc_s = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_FWD;
               end
            end else begin
               state_d = S_CHECK;
            end
         end
         S_FWD: begin
            in_ready  = !fifo_full;
            fifo_data = in_data;
            if (in_valid && !fifo_full) begin
               wrreq = 1'b1;
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  pkt_inc_s = 1'b1;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_FWD;
               end
            end else begin
               state_d = S_FWD;
            end
         end
         S_DROP: begin
            in_ready = 1'b1;
            if (in_valid) begin
               rem_d = rem_q - 4'd1;
               if (rem_q == 4'd1) begin
                  drop_inc_s = 1'b1;
                  state_d    = S_IDLE;
               end else begin
                  state_d = S_DROP;
               end
            end else begin
               state_d = S_DROP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, header/remaining-byte tracking and saturating packet counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hdr_q      <= 8'h00;
         rem_q      <= 4'd0;
         pkt_cnt_q  <= 16'd0;
         drop_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         hdr_q   <= hdr_d;
         rem_q   <= rem_d;
         if (pkt_inc_s) begin
            pkt_cnt_q <= sat_inc(pkt_cnt_q);
         end
         if (drop_inc_s) begin
            drop_cnt_q <= sat_inc(drop_cnt_q);
         end
      end
   end

   assign pkt_cnt  = pkt_cnt_q;
   assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_port_ingress_writer.sv
// Bench for port_ingress_writer: directed per-cycle vector table, reset-mid-packet
// sequence, and randomized packet streams checked against a packet-level model.
module tb_port_ingress_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  fifo_data;
   logic        wrreq;
   logic        fifo_full;
   logic [7:0]  fifo_usedw;
   logic [15:0] pkt_cnt;
   logic [15:0] drop_cnt;

   int n_pass  = 0;
   int n_total = 0;

   port_ingress_writer #(.FIFO_DEPTH(256), .AW(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .fifo_data (fifo_data),
      .wrreq     (wrreq),
      .fifo_full (fifo_full),
      .fifo_usedw(fifo_usedw),
      .pkt_cnt   (pkt_cnt),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        v;
      logic        full;
      logic [7:0]  uw;
      logic        rdy;
      logic        wr;
      logic [7:0]  fd;
      logic [15:0] pk;
      logic [15:0] dr;
   } vec_t;

   vec_t tbl[$];
   logic [15:0] pk_e, dr_e;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic void add(input logic [7:0] d, input logic v, input logic full,
                               input logic [7:0] uw, input logic rdy, input logic wr,
                               input logic [7:0] fd);
      vec_t r;
      r.d = d; r.v = v; r.full = full; r.uw = uw;
      r.rdy = rdy; r.wr = wr; r.fd = fd; r.pk = pk_e; r.dr = dr_e;
      tbl.push_back(r);
   endfunction

   task automatic do_reset();
      in_valid = 1'b0; in_data = 8'h00; fifo_full = 1'b0; fifo_usedw = 8'd0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic [7:0] d, input logic v, input logic full, input logic [7:0] uw);
      @(negedge clk);
      in_data = d; in_valid = v; fifo_full = full; fifo_usedw = uw;
      #1;
   endtask

   initial begin
      logic [7:0] stream[$];
      logic [7:0] exp_q[$];
      logic [7:0] got_q[$];
      int exp_pkt, exp_drop, tail, cyc;
      logic vld;

      do_reset();
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_wrreq", wrreq, 1'b0);
      chk("rst_fifo_data", fifo_data, 8'h00);
      chk("rst_pkt_cnt", pkt_cnt, 16'd0);
      chk("rst_drop_cnt", drop_cnt, 16'd0);

      // directed vector table
      pk_e = 16'd0; dr_e = 16'd0;
      add(8'h31, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h31);
      add(8'hAA, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'hAA);
      add(8'hBB, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'hBB);
      add(8'hCC, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'hCC);
      pk_e = 16'd1;
      add(8'h20, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h00);
      add(8'h11, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h22, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      dr_e = 16'd1;
      add(8'hF2, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd241, 1'b0, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd241, 1'b0, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd240, 1'b0, 1'b1, 8'hF2);
      for (int i = 0; i < 15; i++) begin
         if (i == 5) begin
            for (int k = 0; k < 3; k++) add(8'h45, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 8'h00);
         end
         add(8'h40 + 8'(i), 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'h40 + 8'(i));
      end
      pk_e = 16'd2;
      add(8'h03, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h03);
      pk_e = 16'd3;
      add(8'h12, 1'b1, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);
      add(8'h00, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 8'h12);
      add(8'h77, 1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 8'h77);
      pk_e = 16'd4;
      add(8'h00, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 8'h00);

      foreach (tbl[i]) begin
         drive(tbl[i].d, tbl[i].v, tbl[i].full, tbl[i].uw);
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].rdy);
         chk($sformatf("v%0d_wrreq", i), wrreq, tbl[i].wr);
         if (tbl[i].wr) chk($sformatf("v%0d_fifo_data", i), fifo_data, tbl[i].fd);
         chk($sformatf("v%0d_pkt_cnt", i), pkt_cnt, tbl[i].pk);
         chk($sformatf("v%0d_drop_cnt", i), drop_cnt, tbl[i].dr);
      end

      // reset while forwarding with five payload bytes still owed
      drive(8'h71, 1'b1, 1'b0, 8'd0);
      drive(8'h00, 1'b0, 1'b0, 8'd0);
      chk("mid_hdr_wr", wrreq, 1'b1);
      drive(8'h01, 1'b1, 1'b0, 8'd0);
      drive(8'h02, 1'b1, 1'b0, 8'd0);
      drive(8'h03, 1'b1, 1'b0, 8'd0);
      chk("mid_fwd_wr", wrreq, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wrreq", wrreq, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b1);
      chk("mid_rst_pkt_cnt", pkt_cnt, 16'd0);
      chk("mid_rst_drop_cnt", drop_cnt, 16'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(8'h11, 1'b1, 1'b0, 8'd0);
      chk("post_rst_idle_ready", in_ready, 1'b1);
      drive(8'h00, 1'b0, 1'b0, 8'd0);
      chk("post_rst_hdr_wr", wrreq, 1'b1);
      chk("post_rst_hdr_data", fifo_data, 8'h11);
      drive(8'h5A, 1'b1, 1'b0, 8'd0);
      chk("post_rst_pl_wr", wrreq, 1'b1);
      chk("post_rst_pl_data", fifo_data, 8'h5A);
      drive(8'h00, 1'b0, 1'b0, 8'd0);
      chk("post_rst_pkt_cnt", pkt_cnt, 16'd1);

      // randomized packets against a packet-level model
      do_reset();
      exp_pkt = 0; exp_drop = 0;
      for (int p = 0; p < 60; p++) begin
         logic [7:0] h;
         h = 8'($urandom);
         stream.push_back(h);
         if (h[1:0] != 2'b00) exp_q.push_back(h);
         for (int b = 0; b < int'(h[7:4]); b++) begin
            logic [7:0] pb;
            pb = 8'($urandom);
            stream.push_back(pb);
            if (h[1:0] != 2'b00) exp_q.push_back(pb);
         end
         if (h[1:0] != 2'b00) exp_pkt++;
         else exp_drop++;
      end
      vld = 1'b0; tail = 0; cyc = 0;
      while (tail < 40 && cyc < 30000) begin
         @(negedge clk);
         cyc++;
         if (!vld && stream.size() > 0 && $urandom_range(0, 3) != 0) vld = 1'b1;
         in_valid   = vld;
         in_data    = vld ? stream[0] : 8'h00;
         fifo_full  = ($urandom_range(0, 4) == 0);
         fifo_usedw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'd0;
         #1;
         if (fifo_full) chk("rand_wr_while_full", wrreq, 1'b0);
         if (wrreq) got_q.push_back(fifo_data);
         if (in_valid && in_ready) begin
            void'(stream.pop_front());
            vld = 1'b0;
         end
         if (stream.size() == 0) tail++;
      end
      in_valid = 1'b0; fifo_full = 1'b0; fifo_usedw = 8'd0;
      chk("rand_stream_consumed", stream.size(), 0);
      chk("rand_wr_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         chk($sformatf("rand_byte%0d", i), got_q[i], exp_q[i]);
      chk("rand_pkt_cnt", pkt_cnt, exp_pkt);
      chk("rand_drop_cnt", drop_cnt, exp_drop);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
